// File: rtl/axi_wr_beat_gen_if.sv
// Bundle between the AXI write channels (AW/W/B) and the AHB-side beat
// command/completion path of the axi2ahb bridge write stage.
// The slave modport is the beat generator's view; master is the opposite end.
interface axi_wr_beat_gen_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LEN_WIDTH     = 8,
    parameter int SIZE_WIDTH    = 3,
    parameter int AW_TID_WIDTH  = 1,
    parameter int W_DATA_WIDTH  = 64,
    parameter int B_RESP_WIDTH  = 2
);
    // AW channel
    logic                      aw_valid;
    logic                      aw_ready;
    logic [AW_TID_WIDTH-1:0]   aw_tid;
    logic [ADDRESS_WIDTH-1:0]  aw_addr;
    logic [LEN_WIDTH-1:0]      aw_len;
    logic [SIZE_WIDTH-1:0]     aw_size;
    logic [1:0]                aw_burst;
    // W channel
    logic                      w_valid;
    logic                      w_ready;
    logic [W_DATA_WIDTH-1:0]   w_data;
    logic [W_DATA_WIDTH/8-1:0] w_strb;
    logic                      w_last;
    // B channel
    logic                      b_valid;
    logic                      b_ready;
    logic [AW_TID_WIDTH-1:0]   b_tid;
    logic [B_RESP_WIDTH-1:0]   b_resp;
    // Beat command towards the AHB-side master
    logic                      bt_valid;
    logic                      bt_ready;
    logic [ADDRESS_WIDTH-1:0]  bt_addr;
    logic [SIZE_WIDTH-1:0]     bt_size;
    logic [W_DATA_WIDTH-1:0]   bt_data;
    logic [W_DATA_WIDTH/8-1:0] bt_strb;
    logic                      bt_last;
    // Per-beat completion from the AHB-side master
    logic                      cp_valid;
    logic                      cp_err;

    modport slave (
        input  aw_valid, aw_tid, aw_addr, aw_len, aw_size, aw_burst,
        input  w_valid, w_data, w_strb, w_last,
        input  b_ready, bt_ready, cp_valid, cp_err,
        output aw_ready, w_ready, b_valid, b_tid, b_resp,
        output bt_valid, bt_addr, bt_size, bt_data, bt_strb, bt_last
    );

    modport master (
        output aw_valid, aw_tid, aw_addr, aw_len, aw_size, aw_burst,
        output w_valid, w_data, w_strb, w_last,
        output b_ready, bt_ready, cp_valid, cp_err,
        input  aw_ready, w_ready, b_valid, b_tid, b_resp,
        input  bt_valid, bt_addr, bt_size, bt_data, bt_strb, bt_last
    );
endinterface

// File: rtl/axi_wr_beat_gen.sv
// AXI write-slave stage of the axi2ahb bridge. Accepts one AW burst at a
// time, expands it into per-beat commands (address/size/data/strobe), counts
// per-beat completions and returns one B response per burst.
module axi_wr_beat_gen #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LEN_WIDTH     = 8,
    parameter int SIZE_WIDTH    = 3,
    parameter int AW_TID_WIDTH  = 1,
    parameter int W_DATA_WIDTH  = 64,
    parameter int B_RESP_WIDTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    axi_wr_beat_gen_if.slave   bus,
    output logic               proto_err
);

    localparam int STRB_WIDTH = W_DATA_WIDTH / 8;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE    = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]     LEN_ONE     = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH:0]       OUTST_ZERO  = {(LEN_WIDTH+1){1'b0}};
    localparam logic [LEN_WIDTH:0]       OUTST_ONE   = {{LEN_WIDTH{1'b0}}, 1'b1};
    localparam logic [B_RESP_WIDTH-1:0]  RESP_OKAY   = {B_RESP_WIDTH{1'b0}};
    localparam logic [B_RESP_WIDTH-1:0]  RESP_SLVERR = B_RESP_WIDTH'(2'b10);
    localparam logic [1:0]               BURST_FIXED = 2'b00;
    localparam logic [1:0]               BURST_INCR  = 2'b01;
    localparam logic [1:0]               BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_WAIT_CP = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [AW_TID_WIDTH-1:0]    r_tid;
    logic [ADDRESS_WIDTH-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]       r_len;
    logic [SIZE_WIDTH-1:0]      r_size;
    logic [1:0]                 r_burst;
    logic [ADDRESS_WIDTH-1:0]   r_wrap_lo;
    logic [ADDRESS_WIDTH-1:0]   r_wrap_sz;
    logic [LEN_WIDTH-1:0]       r_beat_cnt;
    logic [LEN_WIDTH:0]         r_outst;
    logic                       r_err;

    logic                       r_aw_ready;
    logic                       r_b_valid;
    logic [AW_TID_WIDTH-1:0]    r_b_tid;
    logic [B_RESP_WIDTH-1:0]    r_b_resp;
    logic                       r_proto_err;

    logic                       w_aw_hs;
    logic                       w_beat_hs;
    logic                       w_b_hs;
    logic                       w_last_beat;
    logic                       w_cp_stray;
    logic                       w_cp_accept;
    logic                       w_proto_err;
    logic [ADDRESS_WIDTH-1:0]   w_bytes;
    logic [ADDRESS_WIDTH-1:0]   w_incr_sum;
    logic [ADDRESS_WIDTH-1:0]   w_addr_nxt;
    logic [ADDRESS_WIDTH-1:0]   w_wrap_sz_new;
    logic [ADDRESS_WIDTH-1:0]   w_wrap_lo_new;
    logic [LEN_WIDTH:0]         w_outst_nxt;

    // Handshake and event decode shared by the FSM and the datapath
    always_comb begin
        w_aw_hs     = r_aw_ready & (r_state == ST_IDLE) & bus.aw_valid;
        w_beat_hs   = (r_state == ST_DATA) & bus.w_valid & bus.bt_ready;
        w_b_hs      = r_b_valid & bus.b_ready;
        w_last_beat = (r_beat_cnt == r_len);
        // A completion with nothing outstanding is only legal if a beat is
        // being issued in the same cycle.
        w_cp_stray  = bus.cp_valid & (r_outst == OUTST_ZERO) & ~w_beat_hs;
        w_cp_accept = bus.cp_valid & ~w_cp_stray;
        w_proto_err = w_cp_stray
                    | (w_beat_hs &  bus.w_last & ~w_last_beat)
                    | (w_beat_hs & ~bus.w_last &  w_last_beat);
    end

    // Beat address sequencing and wrap window of a newly accepted burst
    always_comb begin
        w_bytes       = ADDR_ONE << r_size;
        w_incr_sum    = r_addr + w_bytes;
        w_wrap_sz_new = ({{(ADDRESS_WIDTH-LEN_WIDTH){1'b0}}, bus.aw_len} + ADDR_ONE) << bus.aw_size;
        w_wrap_lo_new = bus.aw_addr & ~(w_wrap_sz_new - ADDR_ONE);
        case (r_burst)
            BURST_INCR: begin
                // Align first so an unaligned start lands on the next boundary
                w_addr_nxt = (r_addr & ~(w_bytes - ADDR_ONE)) + w_bytes;
            end
            BURST_WRAP: begin
                if (w_incr_sum == (r_wrap_lo + r_wrap_sz)) begin
                    w_addr_nxt = r_wrap_lo;
                end else begin
                    w_addr_nxt = w_incr_sum;
                end
            end
            BURST_FIXED: begin
                w_addr_nxt = r_addr;
            end
            default: begin
                // Reserved burst type: hold the address like FIXED
                w_addr_nxt = r_addr;
            end
        endcase
    end

    // Outstanding-beat count: +1 per issued beat, -1 per accepted completion
    always_comb begin
        case ({w_beat_hs, w_cp_accept})
            2'b10:   w_outst_nxt = r_outst + OUTST_ONE;
            2'b01:   w_outst_nxt = r_outst - OUTST_ONE;
            default: w_outst_nxt = r_outst;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_aw_hs) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_beat_hs && w_last_beat) begin
                    w_state_nxt = ST_WAIT_CP;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_WAIT_CP: begin
                if ((r_outst == OUTST_ZERO) || ((r_outst == OUTST_ONE) && bus.cp_valid)) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT_CP;
                end
            end
            ST_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: W to beat-command pass-through while in DATA
    always_comb begin
        bus.bt_valid = 1'b0;
        bus.w_ready  = 1'b0;
        bus.bt_last  = 1'b0;
        bus.bt_addr  = r_addr;
        bus.bt_size  = r_size;
        bus.bt_data  = {W_DATA_WIDTH{1'b0}};
        bus.bt_strb  = {STRB_WIDTH{1'b0}};
        if (r_state == ST_DATA) begin
            bus.bt_valid = bus.w_valid;
            bus.w_ready  = bus.bt_ready;
            bus.bt_last  = w_last_beat;
            bus.bt_data  = bus.w_data;
            bus.bt_strb  = bus.w_strb;
        end else begin
            bus.bt_valid = 1'b0;
            bus.w_ready  = 1'b0;
        end
    end

    // Burst context capture, beat counter, address, outstanding count, error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tid      <= {AW_TID_WIDTH{1'b0}};
            r_addr     <= {ADDRESS_WIDTH{1'b0}};
            r_len      <= {LEN_WIDTH{1'b0}};
            r_size     <= {SIZE_WIDTH{1'b0}};
            r_burst    <= 2'b00;
            r_wrap_lo  <= {ADDRESS_WIDTH{1'b0}};
            r_wrap_sz  <= {ADDRESS_WIDTH{1'b0}};
            r_beat_cnt <= {LEN_WIDTH{1'b0}};
            r_outst    <= OUTST_ZERO;
            r_err      <= 1'b0;
        end else begin
            r_outst <= w_outst_nxt;
            if (w_aw_hs) begin
                r_tid      <= bus.aw_tid;
                r_addr     <= bus.aw_addr;
                r_len      <= bus.aw_len;
                r_size     <= bus.aw_size;
                r_burst    <= bus.aw_burst;
                r_wrap_lo  <= w_wrap_lo_new;
                r_wrap_sz  <= w_wrap_sz_new;
                r_beat_cnt <= {LEN_WIDTH{1'b0}};
            end else if (w_beat_hs) begin
                r_addr     <= w_addr_nxt;
                r_beat_cnt <= r_beat_cnt + LEN_ONE;
            end else begin
                r_addr     <= r_addr;
                r_beat_cnt <= r_beat_cnt;
            end
            // Error is sticky for the burst and cleared only by a new AW
            if (w_aw_hs) begin
                r_err <= 1'b0;
            end else if (w_cp_accept && bus.cp_err) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    // Registered handshake outputs, B response fields and violation pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aw_ready  <= 1'b0;
            r_b_valid   <= 1'b0;
            r_b_tid     <= {AW_TID_WIDTH{1'b0}};
            r_b_resp    <= RESP_OKAY;
            r_proto_err <= 1'b0;
        end else begin
            r_aw_ready  <= (w_state_nxt == ST_IDLE);
            r_b_valid   <= (w_state_nxt == ST_RESP);
            r_proto_err <= w_proto_err;
            // Load once on entry to RESP so the response stays stable until b_ready;
            // an error on the very last completion must still be reported.
            if ((r_state == ST_WAIT_CP) && (w_state_nxt == ST_RESP)) begin
                r_b_tid  <= r_tid;
                r_b_resp <= (r_err || (w_cp_accept && bus.cp_err)) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                r_b_tid  <= r_b_tid;
                r_b_resp <= r_b_resp;
            end
        end
    end

    assign bus.aw_ready = r_aw_ready;
    assign bus.b_valid  = r_b_valid;
    assign bus.b_tid    = r_b_tid;
    assign bus.b_resp   = r_b_resp;
    assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_axi_wr_beat_gen.sv
// Directed bench for axi_wr_beat_gen: INCR / WRAP / FIXED address sequences,
// error response, protocol-violation pulses and mid-burst reset.
module tb_axi_wr_beat_gen;

    logic clk = 1'b0;
    logic rst;
    logic proto_err;

    int n_checks = 0;
    int n_fails  = 0;
    int n_bt_hs  = 0;
    int hs_base  = 0;

    axi_wr_beat_gen_if bus ();

    axi_wr_beat_gen dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // Count accepted beat commands to detect lost or duplicated beats
    always @(posedge clk) begin
        if (bus.bt_valid && bus.bt_ready) begin
            n_bt_hs <= n_bt_hs + 1;
        end
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.aw_valid = 1'b0; bus.aw_tid = 1'b0; bus.aw_addr = 32'h0;
        bus.aw_len = 8'd0; bus.aw_size = 3'd0; bus.aw_burst = 2'b00;
        bus.w_valid = 1'b0; bus.w_data = 64'h0; bus.w_strb = 8'h0; bus.w_last = 1'b0;
        bus.b_ready = 1'b0; bus.bt_ready = 1'b0; bus.cp_valid = 1'b0; bus.cp_err = 1'b0;
    endtask

    // AW handshake; returns one cycle later with the DUT in DATA
    task automatic aw(input logic tid, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        bus.aw_valid = 1'b1; bus.aw_tid = tid; bus.aw_addr = addr;
        bus.aw_len = len; bus.aw_size = size; bus.aw_burst = burst;
        #1;
        check("aw_ready", bus.aw_ready, 1'b1);
        tick;
        bus.aw_valid = 1'b0;
    endtask

    // One W cycle: drive, check the forwarded beat command, clock it
    task automatic beat(input logic [31:0] e_addr, input logic e_last, input logic [63:0] d,
                        input logic [7:0] s, input logic wl, input logic rdy,
                        input logic cpv, input logic cpe, input logic e_perr, input logic [2:0] e_size);
        bus.w_valid = 1'b1; bus.w_data = d; bus.w_strb = s; bus.w_last = wl;
        bus.bt_ready = rdy; bus.cp_valid = cpv; bus.cp_err = cpe;
        #1;
        check("bt_valid", bus.bt_valid, 1'b1);
        check("w_ready", bus.w_ready, rdy);
        check("bt_addr", bus.bt_addr, e_addr);
        check("bt_last", bus.bt_last, e_last);
        check("bt_data", bus.bt_data, d);
        check("bt_strb", bus.bt_strb, s);
        check("bt_size", bus.bt_size, e_size);
        check("proto_err_beat", proto_err, e_perr);
        tick;
        idle_inputs();
    endtask

    // Last completion in WAIT_CP, with W offered to prove it is not accepted
    task automatic final_cp(input logic e_perr);
        bus.cp_valid = 1'b1; bus.w_valid = 1'b1; bus.bt_ready = 1'b1;
        #1;
        check("wait_w_ready", bus.w_ready, 1'b0);
        check("wait_bt_valid", bus.bt_valid, 1'b0);
        check("wait_b_valid", bus.b_valid, 1'b0);
        check("proto_err_wait", proto_err, e_perr);
        tick;
        idle_inputs();
    endtask

    // B response right after the final completion: present, held, then released
    task automatic resp_check(input logic e_tid, input logic [1:0] e_resp);
        #1;
        check("b_valid", bus.b_valid, 1'b1);
        check("b_tid", bus.b_tid, e_tid);
        check("b_resp", bus.b_resp, e_resp);
        check("resp_aw_ready", bus.aw_ready, 1'b0);
        tick;
        #1;
        check("b_valid_hold", bus.b_valid, 1'b1);
        check("b_tid_hold", bus.b_tid, e_tid);
        check("b_resp_hold", bus.b_resp, e_resp);
        bus.b_ready = 1'b1;
        tick;
        bus.b_ready = 1'b0;
        #1;
        check("b_valid_clear", bus.b_valid, 1'b0);
        check("aw_ready_after_b", bus.aw_ready, 1'b1);
        tick;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        // Reset state
        check("rst_aw_ready", bus.aw_ready, 1'b0);
        check("rst_w_ready", bus.w_ready, 1'b0);
        check("rst_b_valid", bus.b_valid, 1'b0);
        check("rst_bt_valid", bus.bt_valid, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_b_tid", bus.b_tid, 1'b0);
        check("rst_b_resp", bus.b_resp, 2'b00);
        tick;
        tick;
        rst = 1'b1;
        tick;
        check("aw_ready_out_of_reset", bus.aw_ready, 1'b1);

        // INCR, unaligned start 0x1004, len 3, size 3, completion every cycle
        aw(1'b1, 32'h1004, 8'd3, 3'd3, 2'b01);
        beat(32'h1004, 1'b0, 64'hA000_0000_0000_00A0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        beat(32'h1008, 1'b0, 64'hA111_0000_0000_00A1, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        beat(32'h1010, 1'b0, 64'hA222_0000_0000_00A2, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        beat(32'h1018, 1'b1, 64'hA333_0000_0000_00A3, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        final_cp(1'b0);
        resp_check(1'b1, 2'b00);

        // WRAP 0x38, len 3, size 2: wraps at 0x40 back to 0x30
        aw(1'b0, 32'h0000_0038, 8'd3, 3'd2, 2'b10);
        beat(32'h38, 1'b0, 64'h0000_0000_B0B0_B0B0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        beat(32'h3C, 1'b0, 64'hB1B1_B1B1_0000_0000, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        beat(32'h30, 1'b0, 64'h0000_0000_B2B2_B2B2, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        beat(32'h34, 1'b1, 64'hB3B3_B3B3_0000_0000, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        final_cp(1'b0);
        resp_check(1'b0, 2'b00);

        // FIXED 0x200, len 2, bt_ready toggling 0/1 on every beat
        hs_base = n_bt_hs;
        aw(1'b1, 32'h0000_0200, 8'd2, 3'd2, 2'b00);
        beat(32'h200, 1'b0, 64'h1111_2222_3333_4444, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        beat(32'h200, 1'b0, 64'h1111_2222_3333_4444, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        beat(32'h200, 1'b0, 64'h5555_6666_7777_8888, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
        beat(32'h200, 1'b0, 64'h5555_6666_7777_8888, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        beat(32'h200, 1'b1, 64'h9999_AAAA_BBBB_CCCC, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
        beat(32'h200, 1'b1, 64'h9999_AAAA_BBBB_CCCC, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        final_cp(1'b0);
        check("fixed_beat_count", 64'(n_bt_hs - hs_base), 64'd3);
        resp_check(1'b1, 2'b00);

        // Error: completions delayed, second one errored -> SLVERR after the 4th
        aw(1'b0, 32'h0000_2000, 8'd3, 3'd3, 2'b01);
        beat(32'h2000, 1'b0, 64'hC0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        beat(32'h2008, 1'b0, 64'hC1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        beat(32'h2010, 1'b0, 64'hC2, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        beat(32'h2018, 1'b1, 64'hC3, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 4; g++) begin
                #1;
                check("err_no_b_early", bus.b_valid, 1'b0);
                tick;
            end
            bus.cp_valid = 1'b1;
            bus.cp_err   = (k == 1) ? 1'b1 : 1'b0;
            #1;
            check("err_no_b_at_cp", bus.b_valid, 1'b0);
            tick;
            bus.cp_valid = 1'b0;
            bus.cp_err   = 1'b0;
        end
        resp_check(1'b0, 2'b10);

        // Protocol: early w_last on beat 1 and missing w_last on beat 3
        hs_base = n_bt_hs;
        aw(1'b1, 32'h0000_3000, 8'd3, 3'd3, 2'b01);
        beat(32'h3000, 1'b0, 64'hD0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        beat(32'h3008, 1'b0, 64'hD1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        beat(32'h3010, 1'b0, 64'hD2, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3);
        beat(32'h3018, 1'b1, 64'hD3, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        final_cp(1'b1);
        check("proto_beat_count", 64'(n_bt_hs - hs_base), 64'd4);
        resp_check(1'b1, 2'b00);

        // Stray completion while IDLE
        bus.cp_valid = 1'b1;
        #1;
        tick;
        bus.cp_valid = 1'b0;
        check("stray_proto_err", proto_err, 1'b1);
        check("stray_aw_ready", bus.aw_ready, 1'b1);
        check("stray_b_valid", bus.b_valid, 1'b0);
        tick;
        check("stray_proto_err_clear", proto_err, 1'b0);
        check("stray_still_idle", bus.aw_ready, 1'b1);

        // Reset after 2 of 4 beats, then a fresh burst
        aw(1'b0, 32'h0000_1000, 8'd3, 3'd3, 2'b01);
        beat(32'h1000, 1'b0, 64'hE0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        beat(32'h1008, 1'b0, 64'hE1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        bus.w_valid = 1'b1;
        bus.bt_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("midrst_aw_ready", bus.aw_ready, 1'b0);
        check("midrst_w_ready", bus.w_ready, 1'b0);
        check("midrst_bt_valid", bus.bt_valid, 1'b0);
        check("midrst_b_valid", bus.b_valid, 1'b0);
        idle_inputs();
        tick;
        tick;
        rst = 1'b1;
        tick;
        check("postrst_aw_ready", bus.aw_ready, 1'b1);
        check("postrst_b_valid", bus.b_valid, 1'b0);
        aw(1'b1, 32'h0000_4000, 8'd1, 3'd3, 2'b01);
        beat(32'h4000, 1'b0, 64'hF0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        beat(32'h4008, 1'b1, 64'hF1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        final_cp(1'b0);
        resp_check(1'b1, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axi_wr_beat_gen.md
Name: axi_wr_beat_gen

Overview:
- AXI write-slave stage in the axi2ahb bridge, placed directly downstream of the AXI write-channel bundle (AW/W/B).
- Accepts one AW burst at a time and expands it into per-beat write commands (address, size, data, strobe) for the AHB-side master.
- Tracks per-beat completions from that master and returns a single B response per burst.
- One burst in flight; no interleaving.

Parameters:
ADDRESS_WIDTH, 32, address width
LEN_WIDTH, 8, AXI length field width
SIZE_WIDTH, 3, AXI size field width
AW_TID_WIDTH, 1, transaction ID width
W_DATA_WIDTH, 64, write data width (bits)
B_RESP_WIDTH, 2, response width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
aw_valid  in  1  AW valid
aw_ready  out  1  AW ready
aw_tid  in  AW_TID_WIDTH  burst ID
aw_addr  in  ADDRESS_WIDTH  start address
aw_len  in  LEN_WIDTH  beats minus 1
aw_size  in  SIZE_WIDTH  log2 bytes per beat
aw_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
w_valid  in  1  W valid
w_ready  out  1  W ready
w_data  in  W_DATA_WIDTH  write data
w_strb  in  W_DATA_WIDTH/8  byte strobes
w_last  in  1  last beat marker
b_valid  out  1  B valid
b_ready  in  1  B ready
b_tid  out  AW_TID_WIDTH  response ID
b_resp  out  B_RESP_WIDTH  00 OKAY, 10 SLVERR
bt_valid  out  1  beat command valid
bt_ready  in  1  beat command ready
bt_addr  out  ADDRESS_WIDTH  beat address
bt_size  out  SIZE_WIDTH  beat size
bt_data  out  W_DATA_WIDTH  beat data
bt_strb  out  W_DATA_WIDTH/8  beat strobes
bt_last  out  1  final beat of burst
cp_valid  in  1  one beat completed (in order, no backpressure)
cp_err  in  1  completed beat errored
proto_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. While rst=0: state IDLE, and aw_ready, w_ready, b_valid, bt_valid and proto_err are 0. b_tid, b_resp, the beat counter, the outstanding counter and the error flag are all 0.
- FSM states: IDLE, DATA, WAIT_CP, RESP.
- IDLE:
  - aw_ready=1.
  - On the AW handshake, register tid, addr, len, size and burst. Clear the beat counter (LEN_WIDTH bits) and the error flag. Go to DATA.
- DATA:
  - Combinational pass-through: bt_valid=w_valid, w_ready=bt_ready, bt_data=w_data, bt_strb=w_strb, bt_size=registered size.
  - bt_last=1 when beat counter == len.
  - A beat handshake (w_valid && bt_ready) increments the beat counter and advances the address.
  - On the handshake with beat counter == len, go to WAIT_CP.
- Address generation, computed in ADDRESS_WIDTH bits modulo 2^ADDRESS_WIDTH with no 4KB check:
  - FIXED: every beat uses aw_addr.
  - INCR: beat 0 uses aw_addr unaligned; beat n>0 uses (aw_addr & ~((1<<size)-1)) + n*(1<<size).
  - WRAP: wrap size = (len+1)<<size; lower bound = aw_addr & ~(wrap size-1); next = addr+(1<<size), and if next == lower bound + wrap size, next = lower bound.
- Outstanding counter (LEN_WIDTH+1 bits):
  - +1 on a beat handshake, -1 on cp_valid; both in the same cycle leaves it unchanged.
  - cp_valid while the counter is 0 (and no beat this cycle) is ignored and pulses proto_err.
  - cp_valid && cp_err sets the error flag (sticky until the next AW).
- WAIT_CP: w_ready=0, bt_valid=0. Go to RESP when the counter is 0, or when the counter is 1 and cp_valid.
- RESP:
  - b_valid=1 (registered), b_tid=registered tid, b_resp = error flag ? 2'b10 : 2'b00.
  - Hold all three stable until b_ready. On the handshake go to IDLE; aw_ready=1 the following cycle.
- w_last checking:
  - w_last=1 on a beat handshake with beat counter < len pulses proto_err; that beat is still forwarded with bt_last=0.
  - w_last=0 on the final counted beat pulses proto_err; the burst still ends on the count.
- w_valid outside DATA is not accepted (w_ready=0).
- Reset mid-burst: immediate return to IDLE. Partial beats are dropped and no B is issued.
- Latency:
  - AW handshake at cycle N, so first bt_valid possible at N+1.
  - Final completion at cycle M, so b_valid at M+1.
  - Minimum burst overhead: 3 cycles beyond the beats.

Test Plan:
- INCR: aw_addr=0x1004, len=3, size=3, cp returned each cycle -> bt_addr 0x1004, 0x1008, 0x1010, 0x1018; bt_last on beat 3 only; then b_resp=00 with b_tid matching aw_tid.
- WRAP: aw_addr=0x38, len=3, size=2 -> bt_addr 0x38, 0x3C, 0x30, 0x34.
- FIXED: aw_addr=0x200, len=2, bt_ready toggling 1/0 -> three beats, all at 0x200; data and strb forwarded unchanged; no beat lost or duplicated.
- Error: INCR len=3, cp_err=1 on the 2nd completion, completions delayed 5 cycles -> b_valid only after the 4th cp_valid; b_resp=2'b10; the next burst with no errors returns 00.
- Protocol: len=3 with w_last on beat 1 -> proto_err pulse; 4 beats still forwarded. A stray cp_valid in IDLE -> proto_err pulse, with no state change.
- Reset: assert rst=0 after 2 of 4 beats -> aw_ready, w_ready, bt_valid and b_valid are 0 immediately; after release, aw_ready=1, no b_valid, and a fresh burst completes normally.
